proc_mem_arbiter: RTL
=====================

Name: proc_mem_arbiter

Overview:
- Merges the processor's instruction-memory and data-memory request streams onto a single shared memory port, and routes responses back to the originating stream.
- Sits directly downstream of the 5-stage pipelined processor's imemreq/dmemreq bypass queues and upstream of the single-ported test memory or cache.
- Arbitration is round-robin. Response routing uses an in-order source-ID FIFO, which relies on the memory returning responses in request order.

Parameters:
- p_max_outstanding, 4, maximum requests in flight (issued, response not yet accepted). Power of two, ≥2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- imemreq_msg  input  mem_req_4B_t  instruction request from processor
- imemreq_val  input  1  instruction request valid
- imemreq_rdy  output  1  instruction request ready
- imemresp_msg  output  mem_resp_4B_t  instruction response to processor
- imemresp_val  output  1  instruction response valid
- imemresp_rdy  input  1  instruction response ready
- dmemreq_msg  input  mem_req_4B_t  data request from processor
- dmemreq_val  input  1  data request valid
- dmemreq_rdy  output  1  data request ready
- dmemresp_msg  output  mem_resp_4B_t  data response to processor
- dmemresp_val  output  1  data response valid
- dmemresp_rdy  input  1  data response ready
- memreq_msg  output  mem_req_4B_t  request to shared memory
- memreq_val  output  1  shared memory request valid
- memreq_rdy  input  1  shared memory request ready
- memresp_msg  input  mem_resp_4B_t  response from shared memory
- memresp_val  input  1  shared memory response valid
- memresp_rdy  output  1  shared memory response ready
- num_outstanding  output  $clog2(p_max_outstanding)+1  current source-ID FIFO occupancy

Behaviour:
- State:
  - rr_last: 1 bit, last granted source (0 = imem, 1 = dmem).
  - srcid FIFO: p_max_outstanding × 1 bit, with head/tail pointers and count.
- Reset (reset==0, asynchronous):
  - rr_last=1, so imem wins the first conflict.
  - FIFO pointers and count = 0.
  - All val/rdy outputs = 0; num_outstanding = 0.
- full = (count==p_max_outstanding); empty = (count==0).
- Grant, combinational:
  - Only one of imem/dmem valid: that source is granted.
  - Both valid: grant the source != rr_last.
  - Neither valid: no grant.
- Request path, zero latency, no buffering:
  - memreq_val = (imemreq_val | dmemreq_val) & !full.
  - memreq_msg = granted source's message, passed unmodified, opaque included.
  - imemreq_rdy = grant_imem & memreq_rdy & !full; dmemreq_rdy likewise.
  - No val depends on any rdy of the same channel.
- Request fire = memreq_val & memreq_rdy. On fire:
  - Push the granted source ID at tail.
  - rr_last = granted source.
  - rr_last is unchanged when there is no fire, so a stalled grant holds its target. This avoids message switching under backpressure.
- Response path, zero latency:
  - head = FIFO[head_ptr].
  - imemresp_val = memresp_val & !empty & (head==0); dmemresp_val = memresp_val & !empty & (head==1).
  - Both response msgs = memresp_msg, unmodified.
  - memresp_rdy = !empty & (head==0 ? imemresp_rdy : dmemresp_rdy).
- Response fire = memresp_val & memresp_rdy: pop the head.
- Simultaneous push and pop:
  - Count unchanged; pointers both advance modulo p_max_outstanding.
  - When full, a push is blocked even if a pop occurs in the same cycle. This keeps memresp_rdy off the combinational path to memreq_val.
- Pointer wrap: from p_max_outstanding-1 to 0.
- Response arriving while empty: memresp_rdy=0 and it is not forwarded. A simulation-only assertion flags this as a protocol error.
- Reset mid-operation: the FIFO is cleared and in-flight responses are orphaned. The memory must share this reset.
- num_outstanding = count, updated at the clock edge.

Test Plan:
- Imem only: read to addr 0x200 at reset release; memory returns data 0xDEADBEEF a cycle later → memreq_msg.addr=0x200 in the same cycle as imemreq_val; imemresp_val=1 with data 0xDEADBEEF; dmemresp_val stays 0; num_outstanding goes 0→1→0.
- Conflict: both valid continuously, memreq_rdy=1, sink always ready → grants alternate imem, dmem, imem, dmem, starting with imem. Responses route alternately to imem and dmem in the same order.
- Backpressure fill: memreq_rdy=1 with memory responses withheld → 4 requests accepted; then memreq_val=0 and both req rdy=0 with num_outstanding=4. One response fires → the next request is accepted only on the following cycle.
- Response stall: head=dmem and dmemresp_rdy=0 while imemresp_rdy=1 → memresp_rdy=0, imemresp_val=0, FIFO unchanged. Raising dmemresp_rdy → pop.
- Stalled grant hold: dmem granted, memreq_rdy=0 for 3 cycles while imem asserts → memreq_msg remains the dmem message. After the fire, imem is granted next.
- Async reset: assert reset=0 mid-cycle with 2 outstanding → outputs clear immediately without a clock edge; num_outstanding=0; the next conflict grants imem first.

Source files
------------

// File: rtl/proc_mem_arbiter.sv
// Round-robin merge of the processor's imem/dmem request streams onto one memory port.
// Responses are steered back through an in-order FIFO of source IDs.
package proc_mem_pkg;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  mem_req_4B_t                          imemreq_msg,
  input  logic                                 imemreq_val,
  output logic                                 imemreq_rdy,
  output mem_resp_4B_t                         imemresp_msg,
  output logic                                 imemresp_val,
  input  logic                                 imemresp_rdy,
  input  mem_req_4B_t                          dmemreq_msg,
  input  logic                                 dmemreq_val,
  output logic                                 dmemreq_rdy,
  output mem_resp_4B_t                         dmemresp_msg,
  output logic                                 dmemresp_val,
  input  logic                                 dmemresp_rdy,
  output mem_req_4B_t                          memreq_msg,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  input  mem_resp_4B_t                         memresp_msg,
  input  logic                                 memresp_val,
  output logic                                 memresp_rdy,
  output logic [$clog2(p_max_outstanding):0]   num_outstanding
);
  localparam int PW = $clog2(p_max_outstanding);
  localparam int CW = PW + 1;

  logic                         rr_last_q, rr_last_d;
  logic [p_max_outstanding-1:0] fifo_q, fifo_d;
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;

  logic full, empty, gnt_imem, gnt_dmem, head_src, req_fire, resp_fire;

  assign full  = (count_q == CW'(p_max_outstanding));
  assign empty = (count_q == '0);

  // rr_last_q==1 favours imem on a conflict, rr_last_q==0 favours dmem
  assign gnt_imem = imemreq_val & (~dmemreq_val | rr_last_q);
  assign gnt_dmem = dmemreq_val & (~imemreq_val | ~rr_last_q);

  // Handshake outputs are gated by reset so they drop the moment reset asserts
  assign memreq_val  = reset & (imemreq_val | dmemreq_val) & ~full;
  assign memreq_msg  = gnt_dmem ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = reset & gnt_imem & memreq_rdy & ~full;
  assign dmemreq_rdy = reset & gnt_dmem & memreq_rdy & ~full;
  assign req_fire    = memreq_val & memreq_rdy;

  assign head_src     = fifo_q[head_q];
  assign imemresp_val = reset & memresp_val & ~empty & ~head_src;
  assign dmemresp_val = reset & memresp_val & ~empty & head_src;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign memresp_rdy  = reset & ~empty & (head_src ? dmemresp_rdy : imemresp_rdy);
  assign resp_fire    = memresp_val & memresp_rdy;

  assign num_outstanding = count_q;

  always_comb begin
    rr_last_d = rr_last_q;
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (req_fire) begin
      fifo_d[tail_q] = gnt_dmem;
      tail_d         = tail_q + PW'(1);
      rr_last_d      = gnt_dmem;
    end
    if (resp_fire) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(req_fire) - CW'(resp_fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q <= 1'b1;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Source-ID storage needs no reset: entries are only read while count_q says they are valid
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifndef SYNTHESIS
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset) !(memresp_val && empty));
`endif
endmodule
